// File: rtl/ifu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// Module : ifu_ctrl_pkg
// Brief  : Shared core widths, constants and fetch-controller state encoding.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package ifu_ctrl_pkg;

    localparam int ADDR_LEN = 32;
    localparam int ISA_LEN  = 32;

    localparam logic [ADDR_LEN-1:0] PC_INC         = 32'd4;
    localparam logic [ISA_LEN-1:0]  RV32I_INST_NOP = 32'h0000_0013;
    localparam logic                ENABLE         = 1'b1;

    typedef enum logic [1:0] {
        IFC_IDLE = 2'd0,
        IFC_REQ  = 2'd1,
        IFC_WAIT = 2'd2,
        IFC_HOLD = 2'd3
    } ifc_state_e;

endpackage

`default_nettype wire

// File: rtl/ifu_ctrl.sv
// ---------------------------------------------------------------------------
// Module : ifu_ctrl
// Brief  : Single-outstanding instruction fetch controller feeding IF/ID.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module ifu_ctrl
    import ifu_ctrl_pkg::*;
#(
    parameter logic [ADDR_LEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                jmp_en,
    input  logic [ADDR_LEN-1:0] jmp_addr,
    output logic                ibus_req,
    output logic [ADDR_LEN-1:0] ibus_addr,
    input  logic                ibus_gnt,
    input  logic                ibus_rvalid,
    input  logic [ISA_LEN-1:0]  ibus_rdata,
    output logic [ISA_LEN-1:0]  inst_o,
    output logic [ADDR_LEN-1:0] pc_o,
    output logic                valid_o
);

    ifc_state_e          state_q, state_d;
    logic [ADDR_LEN-1:0] pc_q, pc_d;
    logic [ADDR_LEN-1:0] req_addr_q, req_addr_d;
    logic                discard_q, discard_d;
    logic [ISA_LEN-1:0]  inst_q, inst_d;
    logic [ADDR_LEN-1:0] pc_out_q, pc_out_d;
    logic                valid_q, valid_d;

    logic                req;
    logic                capture;
    logic                hold_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IFC_IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            discard_q  <= 1'b0;
            inst_q     <= RV32I_INST_NOP;
            pc_out_q   <= RESET_PC;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            discard_q  <= discard_d;
            inst_q     <= inst_d;
            pc_out_q   <= pc_out_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        discard_d  = discard_q;
        req        = 1'b0;
        capture    = 1'b0;

        case (state_q)
            IFC_IDLE: begin
                state_d = IFC_REQ;
                if (jmp_en) begin
                    pc_d = jmp_addr;
                end
            end

            IFC_REQ: begin
                req = (stall != ENABLE);
                if (req && ibus_gnt) begin
                    req_addr_d = pc_q;
                    state_d    = IFC_WAIT;
                    // A redirect racing the grant leaves the issued fetch stale.
                    if (jmp_en) begin
                        pc_d      = jmp_addr;
                        discard_d = 1'b1;
                    end else begin
                        pc_d = pc_q + PC_INC;
                    end
                end else if (jmp_en) begin
                    pc_d = jmp_addr;
                end
            end

            IFC_WAIT: begin
                if (ibus_rvalid) begin
                    state_d   = IFC_REQ;
                    discard_d = 1'b0;
                    if (jmp_en) begin
                        pc_d = jmp_addr;
                    end else if (!discard_q) begin
                        capture = 1'b1;
                        if (stall == ENABLE) begin
                            state_d = IFC_HOLD;
                        end
                    end
                end else if (jmp_en) begin
                    pc_d      = jmp_addr;
                    discard_d = 1'b1;
                end
            end

            IFC_HOLD: begin
                if (jmp_en) begin
                    pc_d    = jmp_addr;
                    state_d = IFC_REQ;
                end else if (stall != ENABLE) begin
                    state_d = IFC_REQ;
                end
            end

            default: begin
                state_d = IFC_IDLE;
            end
        endcase
    end

    // Redirect always flushes the IF/ID payload, even while stalled.
    assign hold_out = (stall == ENABLE) && !jmp_en;

    always_comb begin
        inst_d   = inst_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        if (capture) begin
            inst_d   = ibus_rdata;
            pc_out_d = req_addr_q;
            valid_d  = 1'b1;
        end else if (!hold_out) begin
            inst_d  = RV32I_INST_NOP;
            valid_d = 1'b0;
        end
    end

    assign ibus_req  = req;
    assign ibus_addr = pc_q;
    assign inst_o    = inst_q;
    assign pc_o      = pc_out_q;
    assign valid_o   = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_ifu_ctrl.sv
// ---------------------------------------------------------------------------
// Module : tb_ifu_ctrl
// Brief  : Vector table, reset corner case and randomized run for ifu_ctrl.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ifu_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] IA  = 32'h0010_0093;
    localparam logic [31:0] IB  = 32'h0020_0113;
    localparam logic [31:0] IC  = 32'h0030_0193;
    localparam logic [31:0] ID  = 32'h0040_0213;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        jmp_en;
    logic [31:0] jmp_addr;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_gnt;
    logic        ibus_rvalid;
    logic [31:0] ibus_rdata;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        valid_o;

    int n_chk;
    int n_pass;

    ifu_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .jmp_en     (jmp_en),
        .jmp_addr   (jmp_addr),
        .ibus_req   (ibus_req),
        .ibus_addr  (ibus_addr),
        .ibus_gnt   (ibus_gnt),
        .ibus_rvalid(ibus_rvalid),
        .ibus_rdata (ibus_rdata),
        .inst_o     (inst_o),
        .pc_o       (pc_o),
        .valid_o    (valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        jmp;
        logic [31:0] jaddr;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        bit          drop;
    } txn_t;

    vec_t vt[25];

    function automatic vec_t mk(logic s, logic j, logic [31:0] ja, logic g, logic r,
                                logic [31:0] rd, logic er, logic [31:0] ea,
                                logic ev, logic [31:0] ei, logic [31:0] ep);
        vec_t v;
        v.stall = s;  v.jmp = j;  v.jaddr = ja; v.gnt = g; v.rv = r; v.rdata = rd;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_inst = ei; v.e_pc = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    endtask

    task automatic drive(input logic s, input logic j, input logic [31:0] ja,
                         input logic g, input logic r, input logic [31:0] rd);
        stall = s; jmp_en = j; jmp_addr = ja;
        ibus_gnt = g; ibus_rvalid = r; ibus_rdata = rd;
    endtask

    task automatic chk_out(input string tag, input logic er, input logic [31:0] ea,
                           input logic ev, input logic [31:0] ei, input logic [31:0] ep);
        chk({tag, ".ibus_req"}, {31'd0, ibus_req}, {31'd0, er});
        if (er) chk({tag, ".ibus_addr"}, ibus_addr, ea);
        chk({tag, ".valid_o"}, {31'd0, valid_o}, {31'd0, ev});
        chk({tag, ".inst_o"}, inst_o, ei);
        chk({tag, ".pc_o"}, pc_o, ep);
    endtask

    task automatic step(input logic s, input logic j, input logic [31:0] ja,
                        input logic g, input logic r, input logic [31:0] rd);
        @(posedge clk); #1;
        drive(s, j, ja, g, r, rd);
        @(negedge clk);
    endtask

    // Transaction-level reference state for the randomized run.
    txn_t        m_q[$];
    bit          m_boot;
    bit          m_hold;
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic [31:0] m_pcout;
    bit          m_valid;
    bit          b_pend;
    int          b_cnt;

    task automatic model_reset();
        m_q.delete();
        m_boot = 1'b1; m_hold = 1'b0; m_pc = 32'h0;
        m_inst = NOP; m_pcout = 32'h0; m_valid = 1'b0;
        b_pend = 1'b0; b_cnt = 0;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);

        vt[0]  = mk(0,0,32'h0,0,0,32'h0,     0,32'h0,0,NOP,32'h0);
        vt[1]  = mk(0,0,32'h0,1,0,32'h0,     1,32'h0,0,NOP,32'h0);
        vt[2]  = mk(0,0,32'h0,0,1,IA,        0,32'h0,0,NOP,32'h0);
        vt[3]  = mk(0,0,32'h0,1,0,32'h0,     1,32'h4,1,IA, 32'h0);
        vt[4]  = mk(1,0,32'h0,0,1,IB,        0,32'h0,0,NOP,32'h0);
        vt[5]  = mk(1,0,32'h0,0,0,32'h0,     0,32'h0,1,IB, 32'h4);
        vt[6]  = mk(1,0,32'h0,0,0,32'h0,     0,32'h0,1,IB, 32'h4);
        vt[7]  = mk(0,0,32'h0,0,0,32'h0,     0,32'h0,1,IB, 32'h4);
        vt[8]  = mk(0,0,32'h0,1,0,32'h0,     1,32'h8,0,NOP,32'h4);
        vt[9]  = mk(0,1,32'h100,0,0,32'h0,   0,32'h0,0,NOP,32'h4);
        vt[10] = mk(0,0,32'h0,0,0,32'h0,     0,32'h0,0,NOP,32'h4);
        vt[11] = mk(0,0,32'h0,0,1,IC,        0,32'h0,0,NOP,32'h4);
        vt[12] = mk(0,0,32'h0,1,0,32'h0,     1,32'h100,0,NOP,32'h4);
        vt[13] = mk(0,1,32'h200,0,1,IA,      0,32'h0,0,NOP,32'h4);
        vt[14] = mk(0,0,32'h0,0,0,32'h0,     1,32'h200,0,NOP,32'h4);
        vt[15] = mk(0,1,32'hFFFF_FFFC,0,0,0, 1,32'h200,0,NOP,32'h4);
        vt[16] = mk(0,0,32'h0,1,0,32'h0,     1,32'hFFFF_FFFC,0,NOP,32'h4);
        vt[17] = mk(0,0,32'h0,0,1,ID,        0,32'h0,0,NOP,32'h4);
        vt[18] = mk(1,0,32'h0,1,0,32'h0,     0,32'h0,1,ID, 32'hFFFF_FFFC);
        vt[19] = mk(0,0,32'h0,1,0,32'h0,     1,32'h0,1,ID, 32'hFFFF_FFFC);
        vt[20] = mk(0,0,32'h0,0,0,32'h0,     0,32'h0,0,NOP,32'hFFFF_FFFC);
        vt[21] = mk(0,0,32'h0,0,1,IA,        0,32'h0,0,NOP,32'hFFFF_FFFC);
        vt[22] = mk(0,1,32'h300,1,0,32'h0,   1,32'h4,1,IA, 32'h0);
        vt[23] = mk(0,0,32'h0,0,1,IB,        0,32'h0,0,NOP,32'h0);
        vt[24] = mk(0,0,32'h0,0,0,32'h0,     1,32'h300,0,NOP,32'h0);

        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            drive(vt[i].stall, vt[i].jmp, vt[i].jaddr, vt[i].gnt, vt[i].rv, vt[i].rdata);
            @(negedge clk);
            chk_out($sformatf("vec%0d", i), vt[i].e_req, vt[i].e_addr,
                    vt[i].e_valid, vt[i].e_inst, vt[i].e_pc);
        end

        // Reset while a fetch is outstanding; the late response must be ignored.
        step(0, 0, 0, 1, 0, 0);
        chk_out("rs_req", 1'b1, 32'h300, 1'b0, NOP, 32'h0);
        step(0, 0, 0, 0, 1, IA);
        step(1, 0, 0, 0, 0, 0);
        chk_out("rs_cap", 1'b0, 32'h0, 1'b1, IA, 32'h300);
        step(0, 0, 0, 1, 0, 0);
        chk_out("rs_iss", 1'b1, 32'h304, 1'b1, IA, 32'h300);
        step(0, 0, 0, 0, 0, 0);
        chk_out("rs_wait", 1'b0, 32'h0, 1'b0, NOP, 32'h300);
        #1 rst = 1'b1;
        #1 chk_out("rs_async", 1'b0, 32'h0, 1'b0, NOP, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 0, 0, 0, 1, IC);
        @(negedge clk);
        chk_out("rs_idle", 1'b0, 32'h0, 1'b0, NOP, 32'h0);
        step(0, 0, 0, 0, 1, IC);
        chk_out("rs_req0", 1'b1, 32'h0, 1'b0, NOP, 32'h0);
        step(0, 0, 0, 1, 0, 0);
        chk_out("rs_late", 1'b1, 32'h0, 1'b0, NOP, 32'h0);
        step(0, 0, 0, 0, 1, IB);
        step(0, 0, 0, 0, 0, 0);
        chk_out("rs_fetch", 1'b1, 32'h4, 1'b1, IB, 32'h0);

        // Randomized run against the transaction-level model.
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            logic        s, j, g, r, e_req, grant, cap;
            logic [31:0] ja, rd;
            if (n > 0) begin
                @(posedge clk); #1;
            end
            s  = ($urandom_range(0, 3) == 0);
            j  = ($urandom_range(0, 9) == 0);
            ja = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            g  = ($urandom_range(0, 9) < 7);
            r  = b_pend && (b_cnt == 0);
            rd = $urandom();
            drive(s, j, ja, g, r, rd);
            @(negedge clk);

            e_req = !m_boot && !m_hold && (m_q.size() == 0) && !s;
            chk_out($sformatf("rnd%0d", n), e_req, m_pc, m_valid, m_inst, m_pcout);

            grant = e_req && g;
            cap   = (m_q.size() != 0) && r && !m_q[0].drop && !j;
            if (cap) begin
                m_inst = rd; m_pcout = m_q[0].addr; m_valid = 1'b1;
            end else if (!(s && !j)) begin
                m_inst = NOP; m_valid = 1'b0;
            end
            if (cap) m_hold = s;
            else if (m_hold && (j || !s)) m_hold = 1'b0;
            if (m_q.size() != 0) begin
                if (r) void'(m_q.pop_front());
                else if (j) m_q[0].drop = 1'b1;
            end
            if (grant) m_q.push_back('{addr: m_pc, drop: j});
            if (j) m_pc = ja;
            else if (grant) m_pc = m_pc + 32'd4;
            m_boot = 1'b0;

            if (r) b_pend = 1'b0;
            else if (b_pend) b_cnt--;
            if (grant) begin
                b_pend = 1'b1;
                b_cnt  = $urandom_range(0, 2);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
